alusrc_sequencer: RTL and testbench

Control-side counterpart of the second-operand source mux (`Mux_RegSrc2`): it accepts decoded instructions over a valid/ready handshake and generates the 3-bit `Selection` code, ALU op and write strobe for every micro-step. Single-step instructions issue one step; stack and call instructions issue a two-step micro-sequence using the mux constants (2, 4, 15, 3). It sits between the instruction register and the datapath, and stalls fetch through `InstrReady` while a sequence is running.

---
 rtl/alusrc_pkg.sv | 39 +++
 rtl/alusrc_decode_rom.sv | 87 ++++++++
 rtl/alusrc_sequencer.sv | 156 +++++++++++++++
 tb/tb_alusrc_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alusrc_pkg.sv
`default_nettype none
// ============================================================================
// alusrc_pkg : shared constants for the operand-source sequencer
// Rev 1.0
// ============================================================================
package alusrc_pkg;

  localparam logic [2:0] SEL_REG  = 3'd0;
  localparam logic [2:0] SEL_C2   = 3'd1;
  localparam logic [2:0] SEL_C4   = 3'd2;
  localparam logic [2:0] SEL_C15  = 3'd3;
  localparam logic [2:0] SEL_IMM  = 3'd4;
  localparam logic [2:0] SEL_C3   = 3'd5;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_SRA  = 3'd2;
  localparam logic [2:0] ALU_MUL  = 3'd3;
  localparam logic [2:0] ALU_PASS = 3'd7;

  localparam logic [3:0] OP_RALU  = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_PUSH  = 4'h2;
  localparam logic [3:0] OP_POP   = 4'h3;
  localparam logic [3:0] OP_CALL  = 4'h4;
  localparam logic [3:0] OP_SRA15 = 4'h5;
  localparam logic [3:0] OP_MUL3  = 4'h6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_S0    = 2'd1;
  localparam logic [1:0] ST_S1    = 2'd2;
  localparam logic [1:0] ST_TRAP  = 2'd3;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_MUL3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alusrc_decode_rom.sv
`default_nettype none
// ============================================================================
// alusrc_decode_rom : combinational opcode/step to micro-step table
// Rev 1.0
// ============================================================================
module alusrc_decode_rom
  import alusrc_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] i_op,
  input  logic           i_step,
  output logic [2:0]     o_sel,
  output logic [2:0]     o_aluop,
  output logic           o_regwrite,
  output logic           o_last
);

  always_comb begin
    // Unknown opcodes fall through to a single NOP step.
    o_sel      = SEL_REG;
    o_aluop    = ALU_PASS;
    o_regwrite = 1'b0;
    o_last     = 1'b1;
    case (i_op)
      OP_RALU: begin
        o_sel      = SEL_REG;
        o_aluop    = ALU_ADD;
        o_regwrite = 1'b1;
      end
      OP_ADDI: begin
        o_sel      = SEL_IMM;
        o_aluop    = ALU_ADD;
        o_regwrite = 1'b1;
      end
      OP_PUSH: begin
        if (!i_step) begin
          o_sel      = SEL_C2;
          o_aluop    = ALU_SUB;
          o_regwrite = 1'b1;
          o_last     = 1'b0;
        end else begin
          o_sel      = SEL_REG;
          o_aluop    = ALU_PASS;
          o_regwrite = 1'b0;
        end
      end
      OP_POP: begin
        if (!i_step) begin
          o_sel      = SEL_REG;
          o_aluop    = ALU_PASS;
          o_regwrite = 1'b1;
          o_last     = 1'b0;
        end else begin
          o_sel      = SEL_C2;
          o_aluop    = ALU_ADD;
          o_regwrite = 1'b1;
        end
      end
      OP_CALL: begin
        if (!i_step) begin
          o_sel      = SEL_C2;
          o_aluop    = ALU_SUB;
          o_regwrite = 1'b1;
          o_last     = 1'b0;
        end else begin
          o_sel      = SEL_C4;
          o_aluop    = ALU_ADD;
          o_regwrite = 1'b1;
        end
      end
      OP_SRA15: begin
        o_sel      = SEL_C15;
        o_aluop    = ALU_SRA;
        o_regwrite = 1'b1;
      end
      OP_MUL3: begin
        o_sel      = SEL_C3;
        o_aluop    = ALU_MUL;
        o_regwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alusrc_sequencer.sv
`default_nettype none
// ============================================================================
// alusrc_sequencer : issues operand-mux micro-steps per decoded instruction.
// Optional illegal-opcode trap: ALUSRC_ILLEGAL_TRAP_EN.   Rev 1.0
// ============================================================================
module alusrc_sequencer
  import alusrc_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Instr,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic        Stall,
  output logic [2:0]  Selection,
  output logic [2:0]  AluOp,
  output logic        RegWrite,
  output logic        StepValid,
  output logic        StepIdx,
  output logic        Done,
  output logic        Illegal
);

  logic [1:0]     r_state;
  logic [OPW-1:0] r_op;
  logic [2:0]     r_sel;
  logic [2:0]     r_aluop;
  logic           r_wr;
  logic           r_valid;
  logic           r_idx;
  logic           r_done;
  logic           r_last;

  logic [OPW-1:0] w_new_op;
  logic [2:0]     w_new_sel;
  logic [2:0]     w_new_aluop;
  logic           w_new_wr;
  logic           w_new_last;
  logic [2:0]     w_cur_sel;
  logic [2:0]     w_cur_aluop;
  logic           w_cur_wr;
  logic           w_cur_last;
  logic           w_final;
  logic           w_accept;
  logic           w_new_trap;
  logic           w_unused;

  assign w_new_op = Instr[15 -: OPW];
  assign w_unused = ^Instr[15-OPW:0];

  // Step 0 of the incoming opcode and step 1 of the captured one are both needed
  // in the same cycle, so the table is looked up twice.
  alusrc_decode_rom #(.OPW(OPW)) u_rom_new (
    .i_op       (w_new_op),
    .i_step     (1'b0),
    .o_sel      (w_new_sel),
    .o_aluop    (w_new_aluop),
    .o_regwrite (w_new_wr),
    .o_last     (w_new_last)
  );

  alusrc_decode_rom #(.OPW(OPW)) u_rom_cur (
    .i_op       (r_op),
    .i_step     (1'b1),
    .o_sel      (w_cur_sel),
    .o_aluop    (w_cur_aluop),
    .o_regwrite (w_cur_wr),
    .o_last     (w_cur_last)
  );

  assign w_final    = ((r_state == ST_S0) && r_last) || (r_state == ST_S1) ||
                      (r_state == ST_TRAP);
  assign InstrReady = (r_state == ST_IDLE) || (w_final && !Stall);
  assign w_accept   = InstrValid && InstrReady;

`ifdef ALUSRC_ILLEGAL_TRAP_EN
  logic r_ill;

  assign w_new_trap = !op_is_legal(w_new_op);
  assign Illegal    = r_ill;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ill <= 1'b0;
    end else begin
      r_ill <= w_accept && w_new_trap;
    end
  end
`else
  assign w_new_trap = 1'b0;
  assign Illegal    = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_sel   <= SEL_REG;
      r_aluop <= ALU_PASS;
      r_wr    <= 1'b0;
      r_valid <= 1'b0;
      r_idx   <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op  <= w_new_op;
        r_idx <= 1'b0;
        if (w_new_trap) begin
          r_state <= ST_TRAP;
          r_valid <= 1'b0;
          r_wr    <= 1'b0;
          r_done  <= 1'b1;
          r_last  <= 1'b1;
        end else begin
          r_state <= ST_S0;
          r_valid <= 1'b1;
          r_sel   <= w_new_sel;
          r_aluop <= w_new_aluop;
          r_wr    <= w_new_wr;
          r_done  <= w_new_last;
          r_last  <= w_new_last;
        end
      end else if ((r_state != ST_IDLE) && !Stall) begin
        if ((r_state == ST_S0) && !r_last) begin
          r_state <= ST_S1;
          r_sel   <= w_cur_sel;
          r_aluop <= w_cur_aluop;
          r_wr    <= w_cur_wr;
          r_idx   <= 1'b1;
          r_done  <= w_cur_last;
          r_last  <= w_cur_last;
        end else begin
          // Selection and AluOp deliberately keep their last values.
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_wr    <= 1'b0;
          r_idx   <= 1'b0;
          r_last  <= 1'b0;
        end
      end
    end
  end

  assign Selection = r_sel;
  assign AluOp     = r_aluop;
  assign RegWrite  = r_wr;
  assign StepValid = r_valid;
  assign StepIdx   = r_idx;
  assign Done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alusrc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alusrc_sequencer : scoreboard bench for alusrc_sequencer
// Rev 1.0
// ============================================================================
module tb_alusrc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Instr = 16'h0;
  logic        InstrValid = 1'b0;
  logic        Stall = 1'b0;
  logic        InstrReady;
  logic [2:0]  Selection;
  logic [2:0]  AluOp;
  logic        RegWrite;
  logic        StepValid;
  logic        StepIdx;
  logic        Done;
  logic        Illegal;

  always #5 Clk = ~Clk;

  alusrc_sequencer #(.OPW(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Stall      (Stall),
    .Selection  (Selection),
    .AluOp      (AluOp),
    .RegWrite   (RegWrite),
    .StepValid  (StepValid),
    .StepIdx    (StepIdx),
    .Done       (Done),
    .Illegal    (Illegal)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic [2:0] alu;
    logic       wr;
    logic       idx;
    logic       done;
    logic       ill;
    logic       valid;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk(input int sel, input int alu, input bit wr,
                              input bit idx, input bit done, input bit ill,
                              input bit valid);
    exp_t e;
    e.sel = 3'(sel); e.alu = 3'(alu); e.wr = wr; e.idx = idx;
    e.done = done; e.ill = ill; e.valid = valid;
    return e;
  endfunction

  // Reference: per-opcode micro-program (Selection, AluOp, RegWrite) as listed for the mux.
  task automatic model_push(input logic [3:0] op, output exp_t first, output bit two);
    exp_t s0;
    exp_t s1;
    two = 1'b0;
    s1  = '0;
    case (op)
      4'h0: s0 = mk(0, 0, 1, 0, 1, 0, 1);
      4'h1: s0 = mk(4, 0, 1, 0, 1, 0, 1);
      4'h2: begin s0 = mk(1, 1, 1, 0, 0, 0, 1); s1 = mk(0, 7, 0, 1, 1, 0, 1); two = 1'b1; end
      4'h3: begin s0 = mk(0, 7, 1, 0, 0, 0, 1); s1 = mk(1, 0, 1, 1, 1, 0, 1); two = 1'b1; end
      4'h4: begin s0 = mk(1, 1, 1, 0, 0, 0, 1); s1 = mk(2, 0, 1, 1, 1, 0, 1); two = 1'b1; end
      4'h5: s0 = mk(3, 2, 1, 0, 1, 0, 1);
      4'h6: s0 = mk(5, 3, 1, 0, 1, 0, 1);
`ifdef ALUSRC_ILLEGAL_TRAP_EN
      default: s0 = mk(0, 0, 0, 0, 1, 1, 0);
`else
      default: s0 = mk(0, 7, 0, 0, 1, 0, 1);
`endif
    endcase
    sb.push_back(s0);
    if (two) sb.push_back(s1);
    first = s0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one instruction; returns in the first cycle after the handshake.
  task automatic send(input logic [3:0] op, input int nstall);
    bit   got;
    int   budget;
    exp_t first;
    bit   two;
    Instr      = {op, 12'($urandom)};
    InstrValid = 1'b1;
    Stall      = 1'b0;
    got        = 1'b0;
    budget     = 0;
    while (!got && budget < 50) begin
      @(negedge Clk);
      got = InstrReady;
      @(posedge Clk);
      #1;
      budget++;
    end
    InstrValid = 1'b0;
    Instr      = 16'($urandom);
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL handshake_timeout: op %0h not accepted within %0d cycles", op, budget);
      return;
    end
    model_push(op, first, two);
    if (two && nstall > 0) begin
      Stall = 1'b1;
      for (int k = 0; k < nstall; k++) begin
        @(negedge Clk);
        chk("hold_valid", {7'd0, StepValid}, 8'd1);
        chk("hold_sel",   {5'd0, Selection}, {5'd0, first.sel});
        chk("hold_alu",   {5'd0, AluOp},     {5'd0, first.alu});
        chk("hold_wr",    {7'd0, RegWrite},  {7'd0, first.wr});
        chk("hold_done",  {7'd0, Done},      8'd0);
        @(posedge Clk);
        #1;
      end
      Stall = 1'b0;
    end
  endtask

  // Monitor: a step is consumed in the cycle it is presented without a stall.
  always @(negedge Clk) begin
    exp_t e;
    bit   ok;
    if (!Reset && !Stall && (StepValid || Done || Illegal)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL step_unexpected: got valid=%0d sel=%0d alu=%0d wr=%0d done=%0d ill=%0d, required none",
                 StepValid, Selection, AluOp, RegWrite, Done, Illegal);
      end else begin
        e  = sb.pop_front();
        ok = (StepValid === e.valid) && (RegWrite === e.wr) && (StepIdx === e.idx) &&
             (Done === e.done) && (Illegal === e.ill) &&
             (!e.valid || ((Selection === e.sel) && (AluOp === e.alu)));
        if (!ok) begin
          n_err++;
          $display("FAIL step: got v=%0d sel=%0d alu=%0d wr=%0d idx=%0d done=%0d ill=%0d required v=%0d sel=%0d alu=%0d wr=%0d idx=%0d done=%0d ill=%0d",
                   StepValid, Selection, AluOp, RegWrite, StepIdx, Done, Illegal,
                   e.valid, e.sel, e.alu, e.wr, e.idx, e.done, e.ill);
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {7'd0, InstrReady}, 8'd1);
    chk({tag, "_valid"}, {7'd0, StepValid},  8'd0);
    chk({tag, "_sel"},   {5'd0, Selection},  8'd0);
    chk({tag, "_alu"},   {5'd0, AluOp},      8'd7);
    chk({tag, "_wr"},    {7'd0, RegWrite},   8'd0);
    chk({tag, "_idx"},   {7'd0, StepIdx},    8'd0);
    chk({tag, "_done"},  {7'd0, Done},       8'd0);
    chk({tag, "_ill"},   {7'd0, Illegal},    8'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_reset_vals("rst");
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    chk_reset_vals("idle");
    @(posedge Clk);
    #1;

    // ADDI followed back-to-back by R-ALU
    send(4'h1, 0);
    @(negedge Clk);
    chk("addi_ready", {7'd0, InstrReady}, 8'd1);
    @(posedge Clk);
    #1;
    send(4'h0, 0);
    send(4'h4, 0);
    @(negedge Clk);
    chk("call_s0_ready", {7'd0, InstrReady}, 8'd0);
    @(posedge Clk);
    #1;
    repeat (2) @(posedge Clk);
    #1;

    send(4'h2, 3);
    repeat (3) @(posedge Clk);
    #1;

    // POP abandoned by reset mid-sequence
    send(4'h3, 0);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    sb.delete();
    @(negedge Clk);
    chk_reset_vals("midrst");
    @(posedge Clk);
    #1;

    send(4'hA, 0);
    @(negedge Clk);
`ifdef ALUSRC_ILLEGAL_TRAP_EN
    chk("ill_pulse", {6'd0, Illegal, Done}, 8'd3);
    chk("ill_valid", {7'd0, StepValid}, 8'd0);
`else
    chk("nop_step", {StepValid, Selection, AluOp, RegWrite}, {1'b1, 3'd0, 3'd7, 1'b0});
    chk("nop_ill", {7'd0, Illegal}, 8'd0);
`endif
    @(posedge Clk);
    #1;

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 8) op = int'($urandom_range(0, 6));
      else op = int'($urandom_range(7, 15));
      send(4'(op), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge Clk);
        #1;
      end
    end

    repeat (5) @(posedge Clk);
    #1;
    chk("drain", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
